// File: rtl/wifi_intlv_pkg.sv
// Shared definitions for the WIFI_TX block interleaver: mode encoding and
// the counter width helper.
package wifi_intlv_pkg;

    localparam logic MODE_INTLV   = 1'b0;
    localparam logic MODE_DEINTLV = 1'b1;

    // Never returns less than 1 so that degenerate dimensions still get a real counter.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((32'sd1 <<< w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/intlv_addr_gen.sv
// Row/column address walker over an N_ROWS x N_COLS block, traversed either
// row-major (column fastest) or column-major (row fastest).
module intlv_addr_gen
    import wifi_intlv_pkg::*;
#(
    parameter int N_ROWS = 3,
    parameter int N_COLS = 16,
    localparam int RW = clog2(N_ROWS),
    localparam int CW = clog2(N_COLS),
    localparam int AW = clog2(N_ROWS * N_COLS)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          step,
    input  logic          col_major,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic [AW-1:0] addr,
    output logic          last
);

    logic [RW-1:0] row_r;
    logic [CW-1:0] col_r;
    logic [RW-1:0] row_n_s;
    logic [CW-1:0] col_n_s;
    logic          row_end_s;
    logic          col_end_s;

    assign row_end_s = (row_r == RW'(N_ROWS - 1));
    assign col_end_s = (col_r == CW'(N_COLS - 1));
    assign last      = row_end_s && col_end_s;
    assign row       = row_r;
    assign col       = col_r;
    assign addr      = AW'(row_r) * AW'(N_COLS) + AW'(col_r);

    // Next position: wrap to the origin on the final element, otherwise step the fast index.
    always_comb begin
        row_n_s = row_r;
        col_n_s = col_r;
        if (step) begin
            if (last) begin
                row_n_s = {RW{1'b0}};
                col_n_s = {CW{1'b0}};
            end else if (col_major) begin
                if (row_end_s) begin
                    row_n_s = {RW{1'b0}};
                    col_n_s = col_r + CW'(1'b1);
                end else begin
                    row_n_s = row_r + RW'(1'b1);
                    col_n_s = col_r;
                end
            end else begin
                if (col_end_s) begin
                    col_n_s = {CW{1'b0}};
                    row_n_s = row_r + RW'(1'b1);
                end else begin
                    col_n_s = col_r + CW'(1'b1);
                    row_n_s = row_r;
                end
            end
        end else begin
            row_n_s = row_r;
            col_n_s = col_r;
        end
    end

    // Position registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            row_r <= {RW{1'b0}};
            col_r <= {CW{1'b0}};
        end else begin
            row_r <= row_n_s;
            col_r <= col_n_s;
        end
    end

endmodule

// File: rtl/intlv_pingpong.sv
// Double-buffered block interleaver/deinterleaver with per-block mode and
// valid/ready handshakes on both sides.
module intlv_pingpong
    import wifi_intlv_pkg::*;
#(
    parameter int N_COLS = 16,
    parameter int N_ROWS = 3,
    parameter int WIDTH  = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_mode
);

    localparam int N_BLK = N_ROWS * N_COLS;
    localparam int RW    = clog2(N_ROWS);
    localparam int CW    = clog2(N_COLS);
    localparam int AW    = clog2(N_BLK);

    logic [1:0]       full_r;
    logic             wb_r;
    logic             rb_r;
    logic [1:0]       mode_r;
    logic [WIDTH-1:0] mem_r [0:1][0:N_BLK-1];

    logic             wr_step_s, rd_step_s;
    logic             wr_first_s, wr_col_major_s, rd_col_major_s;
    logic [RW-1:0]    wr_row_s, rd_row_s;
    logic [CW-1:0]    wr_col_s, rd_col_s;
    logic [AW-1:0]    wr_addr_s, rd_addr_s;
    logic             wr_last_s, rd_last_s;
    logic [1:0]       set_mask_s, clr_mask_s;

    assign in_ready  = ~full_r[wb_r];
    assign out_valid = full_r[rb_r];
    assign wr_step_s = in_valid & in_ready;
    assign rd_step_s = out_valid & out_ready;

    // Element 0 walks with the live mode; the rest of the block follows the latched one.
    assign wr_first_s     = (wr_row_s == {RW{1'b0}}) && (wr_col_s == {CW{1'b0}});
    assign wr_col_major_s = wr_first_s ? (mode == MODE_DEINTLV) : (mode_r[wb_r] == MODE_DEINTLV);
    assign rd_col_major_s = (mode_r[rb_r] == MODE_INTLV);

    assign set_mask_s = (wr_step_s && wr_last_s) ? (wb_r ? 2'b10 : 2'b01) : 2'b00;
    assign clr_mask_s = (rd_step_s && rd_last_s) ? (rb_r ? 2'b10 : 2'b01) : 2'b00;

    intlv_addr_gen #(.N_ROWS(N_ROWS), .N_COLS(N_COLS)) u_wr_addr (
        .Clock     (Clock),
        .Reset     (Reset),
        .step      (wr_step_s),
        .col_major (wr_col_major_s),
        .row       (wr_row_s),
        .col       (wr_col_s),
        .addr      (wr_addr_s),
        .last      (wr_last_s)
    );

    intlv_addr_gen #(.N_ROWS(N_ROWS), .N_COLS(N_COLS)) u_rd_addr (
        .Clock     (Clock),
        .Reset     (Reset),
        .step      (rd_step_s),
        .col_major (rd_col_major_s),
        .row       (rd_row_s),
        .col       (rd_col_s),
        .addr      (rd_addr_s),
        .last      (rd_last_s)
    );

    // Bank ownership, full flags and per-bank mode.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            full_r <= 2'b00;
            wb_r   <= 1'b0;
            rb_r   <= 1'b0;
            mode_r <= 2'b00;
        end else begin
            full_r <= (full_r | set_mask_s) & ~clr_mask_s;
            if (wr_step_s && wr_last_s) begin
                wb_r <= ~wb_r;
            end
            if (rd_step_s && rd_last_s) begin
                rb_r <= ~rb_r;
            end
            if (wr_step_s && wr_first_s) begin
                mode_r[wb_r] <= mode;
            end
        end
    end

    // Bank storage; contents survive reset.
    always_ff @(posedge Clock) begin
        if (wr_step_s) begin
            mem_r[wb_r][wr_addr_s] <= in_data;
        end
    end

    // Output element, forced to zero while nothing is presented.
    always_comb begin
        out_data = {WIDTH{1'b0}};
        if (out_valid) begin
            out_data = mem_r[rb_r][rd_addr_s];
        end else begin
            out_data = {WIDTH{1'b0}};
        end
    end

    assign out_last = out_valid && (rd_row_s == RW'(N_ROWS - 1)) && (rd_col_s == CW'(N_COLS - 1));
    assign out_mode = out_valid & mode_r[rb_r];

endmodule

// File: tb/tb_intlv_pingpong.sv
// Directed self-checking bench: a 3x16x1 instance and a 6x16x3 instance.
module tb_intlv_pingpong;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    logic       mode, in_v, sel, rdy_en;
    logic [2:0] in_d;
    logic       in_valid0, in_valid1;
    logic [0:0] in_d0;
    logic       in_ready0, in_ready1, out_valid0, out_valid1;
    logic       out_last0, out_last1, out_mode0, out_mode1;
    logic [0:0] out_data0;
    logic [2:0] out_data1;
    logic       o_ir, o_ov, o_ol, o_om;
    logic [2:0] o_d;

    assign in_valid0 = in_v & ~sel;
    assign in_valid1 = in_v & sel;
    assign in_d0     = in_d[0:0];
    assign o_ir = sel ? in_ready1  : in_ready0;
    assign o_ov = sel ? out_valid1 : out_valid0;
    assign o_ol = sel ? out_last1  : out_last0;
    assign o_om = sel ? out_mode1  : out_mode0;
    assign o_d  = sel ? out_data1  : {2'b00, out_data0};

    intlv_pingpong #(.N_COLS(16), .N_ROWS(3), .WIDTH(1)) u_dut0 (
        .Clock(Clock), .Reset(Reset), .mode(mode),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_d0),
        .out_valid(out_valid0), .out_ready(rdy_en), .out_data(out_data0),
        .out_last(out_last0), .out_mode(out_mode0)
    );

    intlv_pingpong #(.N_COLS(16), .N_ROWS(6), .WIDTH(3)) u_dut1 (
        .Clock(Clock), .Reset(Reset), .mode(mode),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_d),
        .out_valid(out_valid1), .out_ready(rdy_en), .out_data(out_data1),
        .out_last(out_last1), .out_mode(out_mode1)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_total;
    int hold_changes;
    bit hold_have;
    logic [2:0] hold_d;
    logic hold_l, hold_m;

    logic [2:0] src_d[$];
    bit         src_m[$];
    logic [2:0] snk_d[$];
    bit         snk_l[$];
    bit         snk_m[$];
    int         acc_cyc[$];
    int         hs_cyc[$];
    int         low_at[$];
    logic [2:0] orig[$];

    // Input element index carried by output position n of one block.
    function automatic int src_idx(input int n, input bit m, input int r, input int c);
        if (!m) return (n % r) * c + n / r;
        else    return (n % c) * r + n / c;
    endfunction

    task automatic clear_logs();
        src_d.delete(); src_m.delete();
        snk_d.delete(); snk_l.delete(); snk_m.delete();
        acc_cyc.delete(); hs_cyc.delete(); low_at.delete();
        acc_total = 0; hold_changes = 0; hold_have = 1'b0;
    endtask

    // Cycle engine: feeds src_*, logs handshakes, tracks stability under back-pressure.
    task automatic run(input int n_out, input int budget, input bit must_finish);
        int k = 0;
        while (k < budget && !(src_d.size() == 0 && snk_d.size() >= n_out)) begin
            in_v = (src_d.size() != 0);
            if (in_v) begin
                in_d = src_d[0];
                mode = src_m[0];
            end else begin
                in_d = 3'b000;
            end
            @(negedge Clock);
            if (in_v && !o_ir) low_at.push_back(acc_total);
            if (in_v && o_ir) begin
                acc_cyc.push_back(cyc);
                void'(src_d.pop_front());
                void'(src_m.pop_front());
                acc_total++;
            end
            if (o_ov && rdy_en) begin
                snk_d.push_back(o_d); snk_l.push_back(o_ol); snk_m.push_back(o_om);
                hs_cyc.push_back(cyc);
                hold_have = 1'b0;
            end else if (o_ov) begin
                if (hold_have && (o_d !== hold_d || o_ol !== hold_l || o_om !== hold_m))
                    hold_changes++;
                hold_have = 1'b1; hold_d = o_d; hold_l = o_ol; hold_m = o_om;
            end else begin
                hold_have = 1'b0;
            end
            @(posedge Clock); #1;
            cyc++; k++;
        end
        in_v = 1'b0;
        if (must_finish) begin
            vectors++;
            if (src_d.size() != 0 || snk_d.size() < n_out) begin
                miscompares++;
                $display("FAIL timeout got %0d outputs want %0d (pending inputs %0d)",
                         snk_d.size(), n_out, src_d.size());
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; in_v = 1'b0; sel = 1'b0; rdy_en = 1'b0; mode = 1'b0; in_d = 3'b000;
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        vectors++; if (o_ir !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", o_ir); end
        vectors++; if (o_ov !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", o_ov); end
        vectors++; if (o_d !== 3'b000) begin miscompares++; $display("FAIL reset_out_data got %b want 000", o_d); end
        vectors++; if (o_ol !== 1'b0) begin miscompares++; $display("FAIL reset_out_last got %b want 0", o_ol); end
        vectors++; if (o_om !== 1'b0) begin miscompares++; $display("FAIL reset_out_mode got %b want 0", o_om); end
        @(posedge Clock); #1;
    endtask

    // One-hot value at input k; only exp_pos may be nonzero, last only at N-1.
    task automatic test_onehot(input bit s, input int r, input int k, input logic [2:0] val,
                               input bit m, input int exp_pos);
        int nb = r * 16;
        clear_logs();
        sel = s; rdy_en = 1'b1;
        for (int i = 0; i < nb; i++) begin
            src_d.push_back((i == k) ? val : 3'b000);
            src_m.push_back(m);
        end
        run(nb, nb + 100, 1'b1);
        for (int n = 0; n < nb && n < snk_d.size(); n++) begin
            vectors++;
            if (snk_d[n] !== ((n == exp_pos) ? val : 3'b000) || snk_l[n] !== (n == nb - 1) || snk_m[n] !== m) begin
                miscompares++;
                $display("FAIL onehot r=%0d m=%0d pos %0d got d=%b l=%b m=%b want d=%b l=%b m=%b",
                         r, m, n, snk_d[n], snk_l[n], snk_m[n],
                         (n == exp_pos) ? val : 3'b000, n == nb - 1, m);
            end
        end
    endtask

    task automatic test_loopback();
        logic [2:0] mid[$];
        int bad;
        clear_logs(); orig.delete();
        sel = 1'b0; rdy_en = 1'b1;
        for (int i = 0; i < 480; i++) begin
            orig.push_back(3'($urandom & 1));
            src_d.push_back(orig[i]); src_m.push_back(1'b0);
        end
        run(480, 1200, 1'b1);
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int n = 0; n < 48; n++)
                if (b * 48 + n >= snk_d.size() || snk_d[b*48+n] !== orig[b*48 + src_idx(n, 1'b0, 3, 16)]) bad++;
            vectors++;
            if (bad != 0) begin miscompares++; $display("FAIL loop_intlv block %0d got %0d bad elements want 0", b, bad); end
        end
        mid = snk_d;
        clear_logs();
        for (int i = 0; i < mid.size(); i++) begin src_d.push_back(mid[i]); src_m.push_back(1'b1); end
        run(480, 1200, 1'b1);
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int n = 0; n < 48; n++)
                if (b * 48 + n >= snk_d.size() || snk_d[b*48+n] !== orig[b*48+n]) bad++;
            vectors++;
            if (bad != 0) begin miscompares++; $display("FAIL loop_deintlv block %0d got %0d bad elements want 0", b, bad); end
        end
    endtask

    task automatic test_back_to_back();
        int gaps = 0, agaps = 0, bad = 0;
        clear_logs(); orig.delete();
        sel = 1'b0; rdy_en = 1'b1;
        for (int i = 0; i < 192; i++) begin
            orig.push_back(3'($urandom & 1));
            src_d.push_back(orig[i]); src_m.push_back(1'b0);
        end
        run(192, 400, 1'b1);
        vectors++; if (low_at.size() != 0) begin miscompares++; $display("FAIL b2b_in_ready_low got %0d stalls want 0", low_at.size()); end
        vectors++;
        if (acc_cyc.size() < 48 || hs_cyc.size() == 0 || hs_cyc[0] != acc_cyc[47] + 1) begin
            miscompares++;
            $display("FAIL b2b_latency got first out cycle %0d want %0d",
                     (hs_cyc.size() > 0) ? hs_cyc[0] : -1, (acc_cyc.size() >= 48) ? acc_cyc[47] + 1 : -1);
        end
        for (int i = 1; i < hs_cyc.size(); i++) if (hs_cyc[i] != hs_cyc[i-1] + 1) gaps++;
        for (int i = 1; i < acc_cyc.size(); i++) if (acc_cyc[i] != acc_cyc[i-1] + 1) agaps++;
        vectors++; if (gaps != 0) begin miscompares++; $display("FAIL b2b_out_gaps got %0d want 0", gaps); end
        vectors++; if (agaps != 0) begin miscompares++; $display("FAIL b2b_in_gaps got %0d want 0", agaps); end
        for (int i = 0; i < 192 && i < snk_d.size(); i++)
            if (snk_d[i] !== orig[(i/48)*48 + src_idx(i % 48, 1'b0, 3, 16)] || snk_l[i] !== (i % 48 == 47)) bad++;
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL b2b_data got %0d bad elements want 0", bad); end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        clear_logs(); orig.delete();
        sel = 1'b0; rdy_en = 1'b0;
        for (int i = 0; i < 144; i++) begin
            orig.push_back(3'($urandom & 1));
            src_d.push_back(orig[i]); src_m.push_back(i >= 48 && i < 96);
        end
        run(0, 110, 1'b0);
        vectors++; if (acc_total != 96) begin miscompares++; $display("FAIL bp_accepted got %0d want 96", acc_total); end
        vectors++;
        if (low_at.size() == 0 || low_at[0] != 96) begin
            miscompares++;
            $display("FAIL bp_stall_index got %0d want 96", (low_at.size() > 0) ? low_at[0] : -1);
        end
        vectors++; if (hold_changes != 0) begin miscompares++; $display("FAIL bp_hold_stable got %0d changes want 0", hold_changes); end
        vectors++; if (o_ov !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid got %b want 1", o_ov); end
        rdy_en = 1'b1;
        run(144, 400, 1'b1);
        for (int i = 0; i < 144 && i < snk_d.size(); i++) begin
            bit m = (i >= 48 && i < 96);
            if (snk_d[i] !== orig[(i/48)*48 + src_idx(i % 48, m, 3, 16)] || snk_l[i] !== (i % 48 == 47) || snk_m[i] !== m) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL bp_release_data got %0d bad elements want 0", bad); end
    endtask

    task automatic test_mode_toggle();
        int bad = 0;
        clear_logs(); orig.delete();
        sel = 1'b0; rdy_en = 1'b1;
        for (int i = 0; i < 96; i++) begin
            orig.push_back(3'($urandom & 1));
            src_d.push_back(orig[i]);
            src_m.push_back((i < 48) ? (i % 48 >= 20) : (i % 48 < 20));
        end
        run(96, 300, 1'b1);
        for (int i = 0; i < 96 && i < snk_d.size(); i++) begin
            bit m = (i >= 48);
            if (snk_d[i] !== orig[(i/48)*48 + src_idx(i % 48, m, 3, 16)]) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL toggle_data got %0d bad elements want 0", bad); end
        vectors++; if (snk_m.size() < 96 || snk_m[10] !== 1'b0) begin miscompares++; $display("FAIL toggle_mode_blk0 got %b want 0", (snk_m.size() > 10) ? snk_m[10] : 1'bx); end
        vectors++; if (snk_m.size() < 96 || snk_m[60] !== 1'b1) begin miscompares++; $display("FAIL toggle_mode_blk1 got %b want 1", (snk_m.size() > 60) ? snk_m[60] : 1'bx); end
    endtask

    task automatic test_reset_midblock();
        int bad = 0, lasts = 0;
        clear_logs(); orig.delete();
        sel = 1'b0; rdy_en = 1'b1;
        for (int i = 0; i < 48; i++) begin src_d.push_back(3'($urandom & 1)); src_m.push_back(1'b0); end
        run(48, 200, 1'b1);
        rdy_en = 1'b0;
        for (int i = 0; i < 68; i++) begin src_d.push_back(3'b001); src_m.push_back(1'b0); end
        run(48, 200, 1'b1);
        vectors++; if (o_ov !== 1'b1 || o_ir !== 1'b1) begin miscompares++; $display("FAIL midrst_pre got valid=%b ready=%b want 1 1", o_ov, o_ir); end
        Reset = 1'b1;
        @(posedge Clock); #1 Reset = 1'b0;
        @(negedge Clock);
        vectors++; if (o_ov !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid got %b want 0", o_ov); end
        vectors++; if (o_ir !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready got %b want 1", o_ir); end
        vectors++; if (o_d !== 3'b000 || o_ol !== 1'b0 || o_om !== 1'b0) begin miscompares++; $display("FAIL midrst_outputs got d=%b l=%b m=%b want 000 0 0", o_d, o_ol, o_om); end
        @(posedge Clock); #1;
        clear_logs();
        rdy_en = 1'b1;
        for (int i = 0; i < 48; i++) begin
            orig.push_back(3'((i % 5 == 0) ? 0 : 1));
            src_d.push_back(orig[i]); src_m.push_back(1'b1);
        end
        run(48, 200, 1'b1);
        for (int i = 0; i < snk_d.size(); i++) begin
            if (i >= 48 || snk_d[i] !== orig[src_idx(i, 1'b1, 3, 16)] || snk_m[i] !== 1'b1) bad++;
            if (snk_l[i]) lasts++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL midrst_block got %0d bad elements want 0", bad); end
        vectors++; if (lasts != 1 || snk_l.size() != 48 || !snk_l[47]) begin miscompares++; $display("FAIL midrst_last got %0d lasts want 1 at 47", lasts); end
    endtask

    initial begin
        test_reset();
        test_onehot(1'b0, 3, 1, 3'b001, 1'b0, 3);
        test_onehot(1'b0, 3, 3, 3'b001, 1'b1, 1);
        test_loopback();
        test_back_to_back();
        test_backpressure();
        test_mode_toggle();
        test_reset_midblock();
        test_onehot(1'b1, 6, 1, 3'b101, 1'b0, 6);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
